// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter_if
//  Description : Bundle of the writeback arbiter's source ports (A and B) and
//                its register-bank write port, plus the pending-write mask and
//                FIFO occupancy exported to the hazard unit.
//                  master : the arbiter's view (drives bank / b_ready / status)
//                  slave  : the environment's view (drives A and B sources)
//  Revision    : 1.0  initial release
// ============================================================================
interface writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Port A: single-cycle results, no backpressure
    logic                       a_valid;
    logic [ADDR_WIDTH-1:0]      a_register;
    logic [DATA_WIDTH-1:0]      a_data;
    // Port B: buffered results, valid/ready
    logic                       b_valid;
    logic                       b_ready;
    logic [ADDR_WIDTH-1:0]      b_register;
    logic [DATA_WIDTH-1:0]      b_data;
    // Register-bank write port
    logic                       reg_write;
    logic [ADDR_WIDTH-1:0]      write_register;
    logic [DATA_WIDTH-1:0]      write_data;
    // Status
    logic [(1<<ADDR_WIDTH)-1:0] pending_mask;
    logic [CNT_W-1:0]           fifo_count;

    modport master (
        input  a_valid, a_register, a_data,
        input  b_valid, b_register, b_data,
        output b_ready,
        output reg_write, write_register, write_data,
        output pending_mask, fifo_count
    );

    modport slave (
        output a_valid, a_register, a_data,
        output b_valid, b_register, b_data,
        input  b_ready,
        input  reg_write, write_register, write_data,
        input  pending_mask, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Merges port A (ALU, highest priority, no backpressure) and
//                port B (loads / multi-cycle, DEPTH-entry FIFO) onto the
//                register-bank write port. Older queued writes to a register
//                that port A overwrites are squashed so program order holds.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous, active-low reset
//                bus    - writeback_arbiter_if.master (A/B sources, bank write
//                         port, pending_mask, fifo_count, b_ready)
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input wire                   clock,
    input wire                   reset,
    writeback_arbiter_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_WIDTH;

    // FIFO storage; dest/data need no reset because live_q gates their use
    logic [ADDR_WIDTH-1:0] dest_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      live_q;
    logic [DEPTH-1:0]      live_d;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic                  reg_write_q;
    logic [ADDR_WIDTH-1:0] write_register_q;
    logic [DATA_WIDTH-1:0] write_data_q;

    logic                  b_ready_w;
    logic                  push_w;
    logic                  pop_w;
    logic                  a_issue_w;
    logic [NREG-1:0]       pending_w;

    // b_ready depends on registered occupancy only; a same-cycle pop does
    // not open a slot until the next cycle.
    assign b_ready_w = (count_q < CNT_W'(DEPTH));
    assign push_w    = bus.b_valid && b_ready_w;
    // Register 0 is hardwired, so an A write to it is treated as no request.
    assign a_issue_w = bus.a_valid && (bus.a_register != '0);
    assign pop_w     = !a_issue_w && (count_q != '0);

    assign count_d   = count_q + CNT_W'(push_w) - CNT_W'(pop_w);

    // Order matters: squash sees only entries already present, then the pop
    // frees the head, then the push installs the (younger, unsquashed) entry.
    // Head and tail never coincide on a push+pop because a full FIFO cannot
    // accept.
    always_comb begin
        live_d = live_q;
        if (a_issue_w) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dest_q[i] == bus.a_register) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop_w) begin
            live_d[head_q] = 1'b0;
        end
        if (push_w) begin
            live_d[tail_q] = (bus.b_register != '0);
        end
    end

    always_comb begin
        pending_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_w[dest_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            live_q           <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            if (push_w) begin
                dest_q[tail_q] <= bus.b_register;
                data_q[tail_q] <= bus.b_data;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop_w) begin
                head_q <= head_q + 1'b1;
            end
            // Issue selection: A first, else live FIFO head; a dead head is
            // consumed silently. Address/data hold when nothing issues.
            if (a_issue_w) begin
                reg_write_q      <= 1'b1;
                write_register_q <= bus.a_register;
                write_data_q     <= bus.a_data;
            end else if (pop_w && live_q[head_q]) begin
                reg_write_q      <= 1'b1;
                write_register_q <= dest_q[head_q];
                write_data_q     <= data_q[head_q];
            end else begin
                reg_write_q      <= 1'b0;
            end
        end
    end

    assign bus.b_ready        = b_ready_w;
    assign bus.reg_write      = reg_write_q;
    assign bus.write_register = write_register_q;
    assign bus.write_data     = write_data_q;
    assign bus.pending_mask   = pending_w;
    assign bus.fifo_count     = count_q;
endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Self-checking bench for writeback_arbiter. A queue-based
//                model of the port-B FIFO and a register-bank array predict
//                every output each cycle; directed literal expectations pin
//                the model on the interesting cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    writeback_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) bus ();

    writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Bank as the DUT actually writes it
    logic [DW-1:0] dut_bank [32] = '{default: '0};
    always @(posedge clock) begin
        if (bus.reg_write) dut_bank[bus.write_register] <= bus.write_data;
    end

    // ---------------- model ----------------
    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] m_bank [32];
    bit            exp_rw = 1'b0;
    logic [AW-1:0] exp_wr = '0;
    logic [DW-1:0] exp_wd = '0;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].r] = 1'b1;
        return m;
    endfunction

    // Applies one clock edge to the model using the inputs present at it.
    task automatic model_step();
        bit   accept;
        ent_t e;
        if (exp_rw) m_bank[exp_wr] = exp_wd;
        if (!reset) begin
            mq.delete();
            exp_rw = 1'b0; exp_wr = '0; exp_wd = '0;
        end else begin
            accept = bus.b_valid && (mq.size() < DP);
            if (bus.a_valid && bus.a_register != 0) begin
                exp_rw = 1'b1; exp_wr = bus.a_register; exp_wd = bus.a_data;
                foreach (mq[i]) if (mq[i].r == bus.a_register) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_rw = e.live;
                if (e.live) begin exp_wr = e.r; exp_wd = e.d; end
            end else begin
                exp_rw = 1'b0;
            end
            if (accept) mq.push_back('{r: bus.b_register, d: bus.b_data,
                                       live: (bus.b_register != 0)});
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("reg_write",      64'(bus.reg_write),      64'(exp_rw));
        chk("write_register", 64'(bus.write_register), 64'(exp_wr));
        chk("write_data",     64'(bus.write_data),     64'(exp_wd));
        chk("b_ready",        64'(bus.b_ready),        64'(mq.size() < DP));
        chk("fifo_count",     64'(bus.fifo_count),     64'(mq.size()));
        chk("pending_mask",   64'(bus.pending_mask),   64'(model_mask()));
    endtask

    // One clock: inputs already set; edge; model update; compare at negedge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic push_b(input logic [AW-1:0] r, input logic [DW-1:0] d);
        bit done = 1'b0;
        bus.b_valid = 1'b1; bus.b_register = r; bus.b_data = d;
        for (int t = 0; t < 20 && !done; t++) begin
            done = (mq.size() < DP);
            cycle();
        end
        if (!done) chk("push_timeout", 64'(done), 64'd1);
        bus.b_valid = 1'b0;
    endtask

    logic [AW-1:0] wrap_regs [7];

    initial begin
        foreach (m_bank[i]) m_bank[i] = '0;
        bus.a_valid = 1'b0; bus.a_register = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_register = '0; bus.b_data = '0;
        wrap_regs = '{5'd0, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

        // Reset
        reset = 1'b0;
        cycle(); cycle();
        chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
        chk("rst_b_ready",   64'(bus.b_ready),   64'd1);
        reset = 1'b1;

        // Port A only, then A to register 0
        bus.a_valid = 1'b1; bus.a_register = 5'd8; bus.a_data = 32'h1234;
        cycle();
        chk("a_reg_write", 64'(bus.reg_write),      64'd1);
        chk("a_wreg",      64'(bus.write_register), 64'd8);
        chk("a_wdata",     64'(bus.write_data),     64'h1234);
        bus.a_register = 5'd0; bus.a_data = 32'h5555;
        cycle();
        chk("a0_no_write", 64'(bus.reg_write),      64'd0);
        chk("a0_hold_reg", 64'(bus.write_register), 64'd8);

        // Fill while A busy on 9, then drain
        bus.a_register = 5'd9; bus.a_data = 32'h99;
        for (int r = 2; r <= 5; r++) push_b(AW'(r), DW'(32'h100 + r));
        chk("full_count",   64'(bus.fifo_count),   64'd4);
        chk("full_b_ready", 64'(bus.b_ready),      64'd0);
        chk("full_pending", 64'(bus.pending_mask), 64'h3C);
        bus.b_valid = 1'b1; bus.b_register = 5'd6; bus.b_data = 32'h106;
        cycle();
        chk("full_ignored", 64'(bus.fifo_count), 64'd4);
        bus.b_valid = 1'b0; bus.a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("drain_reg",  64'(bus.write_register), 64'(2 + k));
            chk("drain_data", 64'(bus.write_data),     64'(32'h102 + k));
            if (k == 0) chk("drain_b_ready", 64'(bus.b_ready), 64'd1);
        end
        cycle();

        // Squash: queued B to 10 overtaken by A to 10
        push_b(5'd10, 32'hAA);
        chk("sq_pending_set", 64'(bus.pending_mask), 64'h400);
        bus.a_valid = 1'b1; bus.a_register = 5'd10; bus.a_data = 32'hBB;
        cycle();
        chk("sq_pending_clr", 64'(bus.pending_mask), 64'h0);
        chk("sq_count",       64'(bus.fifo_count),   64'd1);
        bus.a_valid = 1'b0;
        cycle();
        chk("sq_dead_pop", 64'(bus.reg_write), 64'd0);
        cycle();
        chk("sq_bank_dut",   64'(dut_bank[10]), 64'hBB);
        chk("sq_bank_model", 64'(m_bank[10]),   64'hBB);

        // Same-cycle A and B to register 7
        bus.a_valid = 1'b1; bus.a_register = 5'd7; bus.a_data = 32'h1;
        push_b(5'd7, 32'h2);
        chk("same_a_data",  64'(bus.write_data),   64'h1);
        chk("same_pending", 64'(bus.pending_mask), 64'h80);
        bus.a_valid = 1'b0;
        cycle();
        chk("same_b_data", 64'(bus.write_data), 64'h2);
        cycle();
        chk("same_bank", 64'(dut_bank[7]), 64'h2);

        // Register-0 entry plus pointer wrap
        bus.a_valid = 1'b1; bus.a_register = 5'd20; bus.a_data = 32'h20;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) bus.a_valid = 1'b0;
            push_b(wrap_regs[i], DW'(32'hC00 + i));
        end
        for (int i = 0; i < 8; i++) cycle();
        for (int i = 1; i < 7; i++)
            chk("wrap_bank", 64'(dut_bank[wrap_regs[i]]), 64'(32'hC00 + i));
        chk("wrap_r0", 64'(dut_bank[0]), 64'd0);

        // Reset mid-stream with 3 entries queued
        bus.a_valid = 1'b1; bus.a_register = 5'd21; bus.a_data = 32'h21;
        for (int r = 22; r <= 24; r++) push_b(AW'(r), DW'(32'h200 + r));
        chk("pre_rst_count", 64'(bus.fifo_count), 64'd3);
        reset = 1'b0;
        cycle(); cycle();
        chk("mrst_reg_write", 64'(bus.reg_write),    64'd0);
        chk("mrst_count",     64'(bus.fifo_count),   64'd0);
        chk("mrst_pending",   64'(bus.pending_mask), 64'd0);
        chk("mrst_b_ready",   64'(bus.b_ready),      64'd1);
        reset = 1'b1; bus.a_valid = 1'b0;
        cycle();
        chk("post_rst_idle", 64'(bus.reg_write), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Master side of the register-bank write port. Drives the bank's reg_write / write_register / write_data inputs.
- Merges two writeback sources:
  - Port A: single-cycle ALU results. No backpressure, highest priority.
  - Port B: load / multi-cycle results. valid/ready, buffered in a DEPTH-entry FIFO.
- Exports a pending-write mask so the hazard unit can stall readers of registers with queued writes.

Parameters:
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register index width (32 registers)
- DEPTH, 4, port-B FIFO entries; power of two, >= 2

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- a_valid  in  1  port-A result valid this cycle
- a_register  in  ADDR_WIDTH  port-A destination
- a_data  in  DATA_WIDTH  port-A value
- b_valid  in  1  port-B request
- b_ready  out  1  port-B accept
- b_register  in  ADDR_WIDTH  port-B destination
- b_data  in  DATA_WIDTH  port-B value
- reg_write  out  1  to register bank write enable
- write_register  out  ADDR_WIDTH  to register bank
- write_data  out  DATA_WIDTH  to register bank
- pending_mask  out  2^ADDR_WIDTH  bit r set while any live FIFO entry targets r
- fifo_count  out  log2(DEPTH)+1  occupied FIFO slots, live plus squashed

Behaviour:
- Reset: applied when reset==0 at a clock edge.
  - reg_write=0, write_register=0, write_data=0.
  - FIFO emptied, all live bits cleared, fifo_count=0, pending_mask=0, b_ready=1.
  - Reset mid-stream drops all queued entries; no write is issued on the reset cycle.
- Outputs: reg_write, write_register and write_data are registered. A write issued in cycle N appears at the bank in cycle N+1; the bank commits it at the end of N+1.
- Port B handshake:
  - Transfer occurs when b_valid && b_ready.
  - b_ready = (fifo_count < DEPTH), from registered state only. A pop in the same cycle does not raise b_ready.
  - The entry is written at the tail with live=1.
  - b_register==0: handshake completes but the entry is stored live=0. Register 0 is never written.
- Per-cycle issue selection, in priority order:
  1. a_valid && a_register!=0: issue A; the FIFO does not pop.
  2. Otherwise, if the FIFO is non-empty, pop the head:
     - live head: issue it;
     - dead head: discarded, reg_write=0 next cycle.
  3. Otherwise reg_write=0 next cycle. write_register and write_data hold their previous values.
- a_valid with a_register==0 counts as no A request; the FIFO may drain that cycle.
- Squash rule (preserves program order):
  - When A issues to register r, every FIFO entry already present whose destination is r gets live cleared at that edge. These entries are older than A and must not overwrite its result.
  - An entry enqueued in the same cycle is younger and is not squashed.
  - A squashed entry still occupies its slot until it reaches the head; it is popped with no write.
- pending_mask is combinational: the OR of one-hot(destination) over live entries. Dead entries and port A never set bits.
- Simultaneous push and pop: fifo_count is unchanged; head and tail pointers both advance.
- Full FIFO: b_ready=0 and b_valid is ignored. A pop that cycle frees a slot, and b_ready rises the next cycle.
- Pointers wrap modulo DEPTH. fifo_count runs 0..DEPTH.

Test Plan:
- Reset: assert reset=0 for 2 cycles with the FIFO holding 3 entries -> reg_write=0, fifo_count=0, pending_mask=0, b_ready=1.
- Port A only: a_valid=1, a_register=8, a_data=0x1234 in cycle N -> cycle N+1 shows reg_write=1, write_register=8, write_data=0x1234. A sent to register 0 -> no write.
- FIFO fill/drain: push B to registers 2,3,4,5 while A is busy on register 9 -> b_ready=0 at fifo_count=4 and pending_mask=0x3C. Then drop A -> writes 2,3,4,5 issue in order over 4 cycles; b_ready returns after the first pop.
- Squash: queue B (register 10, 0xAA), then A writes register 10 with 0xBB -> bank ends with 0xBB; the FIFO pop of register 10 issues no write; pending_mask bit 10 clears on the A issue edge.
- Same-cycle order: A to register 7 with 0x1 and a B push to register 7 with 0x2 in the same cycle -> A issues first, B stays live, final bank value is 0x2.
- B to register 0 plus wrap: push register 0, then 6 more pushes across the pointer wrap -> the register-0 entry is consumed silently; the others write in order with no data corruption.
